// File: rtl/drum_pad_encoder.sv
// Button front end for the painting FSM: 2-flop sync + debounce on start and four pads,
// then a START/RUN/STOP sequencer that emits the registered 6-bit command word.

module drum_pad_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter int CW         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module drum_pad_encoder #(
    parameter int DEB_CYCLES = 50000,
    parameter int HOLD_MIN   = 8,
    parameter int CW         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic [3:0] btn_pad,
    output logic [5:0] cmd,
    output logic       running
);
    localparam logic [5:0]    CMD_IDLE  = 6'b000000;
    localparam logic [5:0]    CMD_START = 6'b000001;
    localparam logic [5:0]    CMD_BAND  = 6'b000010;
    localparam logic [CW-1:0] HOLD      = CW'(HOLD_MIN);

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

    state_t        state;
    logic [4:0]    raw, deb;
    logic          start_q, start_rise;
    logic [3:0]    pads, pick;
    logic [CW-1:0] timer;

    // Bit 0 is the start button, bits 4:1 are lanes 1..4.
    assign raw = {btn_pad, btn_start};

    drum_pad_debounce #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_deb [4:0] (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .level (deb)
    );

    assign start_rise = deb[0] & ~start_q;
    assign pads       = deb[4:1];
    // Isolate the lowest set bit: lowest-index pad wins.
    assign pick       = pads & (~pads + 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cmd     <= CMD_IDLE;
            running <= 1'b0;
            timer   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= deb[0];
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= START;
                        cmd   <= CMD_START;
                    end
                end
                START: begin
                    state   <= RUN;
                    cmd     <= CMD_BAND;
                    running <= 1'b1;
                    timer   <= '0;
                end
                RUN: begin
                    if (start_rise) begin
                        state   <= STOP;
                        cmd     <= CMD_IDLE;
                        running <= 1'b0;
                        timer   <= '0;
                    end else if (timer > CW'(1)) begin
                        timer <= timer - CW'(1);
                    end else begin
                        // Timer of 1 means this is the last held cycle, so the code is
                        // re-evaluated now and a lane shows for exactly HOLD_MIN cycles.
                        timer <= '0;
                        if (cmd[5:2] == 4'd0) begin
                            if (|pick) begin
                                cmd   <= {pick, 2'b00};
                                timer <= HOLD;
                            end
                        end else if (pick != cmd[5:2]) begin
                            // Leaving a lane always passes through the static band.
                            cmd <= CMD_BAND;
                        end
                    end
                end
                STOP: begin
                    state <= IDLE;
                    cmd   <= CMD_IDLE;
                end
                default: begin
                    state   <= IDLE;
                    cmd     <= CMD_IDLE;
                    running <= 1'b0;
                    timer   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_drum_pad_encoder.sv
// Bench for drum_pad_encoder: timed expectations are queued when stimulus is driven
// and compared against cmd/running on the falling edge of the matching cycle.

module tb_drum_pad_encoder;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam logic [5:0] BAND = 6'b000010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic [3:0] btn_pad = 4'b0000;
    logic [5:0] cmd;
    logic       running;

    drum_pad_encoder #(.DEB_CYCLES(DEB), .HOLD_MIN(HOLD), .CW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_pad   (btn_pad),
        .cmd       (cmd),
        .running   (running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [5:0] cmd;
        logic       run;
        string      name;
    } exp_t;

    typedef struct {
        logic [3:0] pad;
        logic [5:0] exp;
        string      name;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Keep the scoreboard ordered by cycle so pushes may come in any order.
    task automatic expect_at(input int at, input logic [5:0] c, input logic r, input string nm);
        exp_t e;
        int   idx;
        e.at = at; e.cmd = c; e.run = r; e.name = nm;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.at != cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", mon_e.name, mon_e.at, cyc);
            end else if (cmd !== mon_e.cmd || running !== mon_e.run) begin
                errors++;
                $display("FAIL %s @%0d: cmd=%b running=%b, expected cmd=%b running=%b",
                         mon_e.name, cyc, cmd, running, mon_e.cmd, mon_e.run);
            end
        end
    end

    vec_t tbl[8];
    int   t0;

    initial begin
        tbl[0] = '{4'b0001, 6'b000100, "lane1"};
        tbl[1] = '{4'b0010, 6'b001000, "lane2"};
        tbl[2] = '{4'b0100, 6'b010000, "lane3"};
        tbl[3] = '{4'b1000, 6'b100000, "lane4"};
        tbl[4] = '{4'b0011, 6'b000100, "pads0011"};
        tbl[5] = '{4'b1100, 6'b010000, "pads1100"};
        tbl[6] = '{4'b1111, 6'b000100, "pads1111"};
        tbl[7] = '{4'b0110, 6'b001000, "pads0110"};

        // Reset, then idle.
        expect_at(2, 6'b0, 1'b0, "in_reset");
        expect_at(3, 6'b0, 1'b0, "in_reset2");
        goto(3);
        reset = 1'b0;
        t0 = cyc;
        expect_at(t0 + 1, 6'b0, 1'b0, "idle_1");
        expect_at(t0 + 50, 6'b0, 1'b0, "idle_50");
        expect_at(t0 + 100, 6'b0, 1'b0, "idle_100");
        goto(t0 + 100);

        // Start: one START cycle, then RUN with the static band.
        t0 = cyc;
        btn_start = 1'b1;
        expect_at(t0 + 6, 6'b0, 1'b0, "start_pre");
        expect_at(t0 + 7, 6'b000001, 1'b0, "start_pulse");
        expect_at(t0 + 8, BAND, 1'b1, "run_band");
        expect_at(t0 + 9, BAND, 1'b1, "run_band2");
        goto(t0 + DEB + 5);
        btn_start = 1'b0;
        goto(t0 + 20);

        // Lane selection and priority, pad held 10 cycles each.
        for (int i = 0; i < 8; i++) begin
            t0 = cyc;
            btn_pad = tbl[i].pad;
            expect_at(t0 + 6, BAND, 1'b1, {tbl[i].name, "_pre"});
            expect_at(t0 + 7, tbl[i].exp, 1'b1, {tbl[i].name, "_on"});
            expect_at(t0 + 14, tbl[i].exp, 1'b1, {tbl[i].name, "_hold"});
            expect_at(t0 + 16, tbl[i].exp, 1'b1, {tbl[i].name, "_late"});
            expect_at(t0 + 17, BAND, 1'b1, {tbl[i].name, "_off"});
            goto(t0 + 10);
            btn_pad = 4'b0000;
            goto(t0 + 22);
        end

        // Bounce of DEB-1 cycles is rejected.
        t0 = cyc;
        btn_pad = 4'b0001;
        expect_at(t0 + 7, BAND, 1'b1, "bounce_a");
        expect_at(t0 + 8, BAND, 1'b1, "bounce_b");
        expect_at(t0 + 12, BAND, 1'b1, "bounce_c");
        goto(t0 + 3);
        btn_pad = 4'b0000;
        goto(t0 + 15);

        // Short pulse on pad 2 still holds its code for HOLD_MIN cycles exactly.
        t0 = cyc;
        btn_pad = 4'b0010;
        expect_at(t0 + 6, BAND, 1'b1, "min_pre");
        expect_at(t0 + 7, 6'b001000, 1'b1, "min_first");
        expect_at(t0 + 10, 6'b001000, 1'b1, "min_mid");
        expect_at(t0 + 14, 6'b001000, 1'b1, "min_last");
        expect_at(t0 + 15, BAND, 1'b1, "min_after");
        expect_at(t0 + 16, BAND, 1'b1, "min_after2");
        goto(t0 + 4);
        btn_pad = 4'b0000;
        goto(t0 + 20);

        // Lane 3 to lane 4 passes through one band cycle.
        t0 = cyc;
        btn_pad = 4'b0100;
        expect_at(t0 + 7, 6'b010000, 1'b1, "l34_l3");
        expect_at(t0 + 26, 6'b010000, 1'b1, "l34_l3_end");
        expect_at(t0 + 27, BAND, 1'b1, "l34_gap");
        expect_at(t0 + 28, 6'b100000, 1'b1, "l34_l4");
        expect_at(t0 + 35, 6'b100000, 1'b1, "l34_l4_hold");
        expect_at(t0 + 37, BAND, 1'b1, "l34_off");
        goto(t0 + 20);
        btn_pad = 4'b1000;
        goto(t0 + 30);
        btn_pad = 4'b0000;
        goto(t0 + 42);

        // start_rise during a lane hold goes to STOP, then IDLE.
        t0 = cyc;
        btn_pad = 4'b0001;
        expect_at(t0 + 7, 6'b000100, 1'b1, "stop_lane");
        expect_at(t0 + 11, 6'b000100, 1'b1, "stop_lane_held");
        expect_at(t0 + 12, 6'b0, 1'b0, "stop_state");
        expect_at(t0 + 13, 6'b0, 1'b0, "stop_idle");
        expect_at(t0 + 16, 6'b0, 1'b0, "stop_idle2");
        goto(t0 + 5);
        btn_start = 1'b1;
        goto(t0 + 10);
        btn_start = 1'b0;
        btn_pad = 4'b0000;
        goto(t0 + 20);

        // Restart, then reset during a lane hold.
        t0 = cyc;
        btn_start = 1'b1;
        expect_at(t0 + 7, 6'b000001, 1'b0, "rs_start");
        expect_at(t0 + 8, BAND, 1'b1, "rs_run");
        expect_at(t0 + 15, 6'b100000, 1'b1, "rs_lane");
        expect_at(t0 + 17, 6'b100000, 1'b1, "rs_lane2");
        expect_at(t0 + 18, 6'b0, 1'b0, "rs_reset");
        expect_at(t0 + 20, 6'b0, 1'b0, "rs_after");
        expect_at(t0 + 24, 6'b0, 1'b0, "rs_after2");
        expect_at(t0 + 30, 6'b0, 1'b0, "rs_no_start");
        goto(t0 + 8);
        btn_start = 1'b0;
        btn_pad = 4'b1000;
        goto(t0 + 17);
        reset = 1'b1;
        goto(t0 + 19);
        reset = 1'b0;
        goto(t0 + 32);
        btn_pad = 4'b0000;

        // Drain the scoreboard with a bounded wait.
        t0 = cyc;
        while (sb.size() > 0 && cyc < t0 + 200) begin
            @(posedge clk);
            #1;
        end
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never checked (due cycle %0d)", mon_e.name, mon_e.at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
